// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES constants, the S-box table and key-schedule state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int NWORDS = 60;
  localparam int NRK    = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Index 0 is never used by the schedule; it keeps RCON[i] aligned with cnt/8.
  localparam logic [7:0] RCON [0:7] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

`default_nettype wire

// File: rtl/aes256_key_sched_if.sv
// ============================================================================
// Module   : aes256_key_sched_if
// Brief    : Start/busy/done handshake and round-key read port of the schedule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes256_key_sched_if;
  logic         start;
  logic [255:0] key_in;
  logic [3:0]   rk_sel;
  logic         busy;
  logic         done;
  logic [127:0] rk_out;

  modport master (output start, key_in, rk_sel, input busy, done, rk_out);
  modport slave  (input start, key_in, rk_sel, output busy, done, rk_out);
endinterface

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// Module   : aes_sbox
// Brief    : Combinational AES forward S-box byte lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  wire logic [7:0] din,
  output logic      [7:0] dout
);
  assign dout = SBOX[din];
endmodule

`default_nettype wire

// File: rtl/aes256_key_sched.sv
// ============================================================================
// Module   : aes256_key_sched
// Brief    : Iterative AES-256 key expansion, one 32-bit word per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes256_key_sched
  import aes_pkg::*;
#(
  parameter int NK = 8,
  parameter int NR = 14
) (
  input wire logic          clk,
  input wire logic          rst_n,
  aes256_key_sched_if.slave kif
);

  localparam int LAST = 4 * (NR + 1) - 1;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_words [0:NWORDS-1];

  logic [5:0]   w_prev_idx;
  logic [5:0]   w_back_idx;
  logic [31:0]  w_prev;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_temp;
  logic [5:0]   w_rk_base;
  logic [127:0] w_rk_out;

  // Indices are clamped while cnt<8 so reads never leave the word array.
  assign w_prev_idx = (r_cnt == 6'd0)    ? 6'd0 : r_cnt - 6'd1;
  assign w_back_idx = (r_cnt < 6'(NK))   ? 6'd0 : r_cnt - 6'(NK);
  assign w_prev     = r_words[w_prev_idx];
  assign w_sub_in   = (r_cnt[2:0] == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (w_sub_in[8*g +: 8]),
      .dout (w_sub_out[8*g +: 8])
    );
  end

  always_comb begin
    w_temp    = w_prev;
    w_rk_base = 6'd0;
    w_rk_out  = '0;
    if (r_cnt[2:0] == 3'd0)
      w_temp = w_sub_out ^ {RCON[r_cnt[5:3]], 24'h0};
    else if (r_cnt[2:0] == 3'd4)
      w_temp = w_sub_out;
    if (r_state == DONE && int'(kif.rk_sel) < NRK) begin
      w_rk_base = {kif.rk_sel, 2'b00};
      w_rk_out  = {r_words[w_rk_base],         r_words[w_rk_base + 6'd1],
                   r_words[w_rk_base + 6'd2],  r_words[w_rk_base + 6'd3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
      for (int i = 0; i < NWORDS; i++)
        r_words[i] <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (kif.start) begin
            for (int i = 0; i < NK; i++)
              r_words[i] <= kif.key_in[255 - 32*i -: 32];
            r_cnt   <= 6'(NK);
            r_state <= EXPAND;
          end
        end
        EXPAND: begin
          r_words[r_cnt] <= r_words[w_back_idx] ^ w_temp;
          r_cnt          <= r_cnt + 6'd1;
          if (r_cnt == 6'(LAST))
            r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign kif.busy   = (r_state == EXPAND);
  assign kif.done   = (r_state == DONE);
  assign kif.rk_out = w_rk_out;

endmodule

`default_nettype wire

// File: doc/aes256_key_sched.md
# aes256_key_sched

Iterative AES-256 key schedule that expands a 256-bit cipher key into the 15 round keys (60 words) used by the AES-256 encryption datapath, one 32-bit word per clock. It sits directly upstream of the encryption datapath and replaces its free-running combinational key expansion. A start/busy/done handshake controls it, and a random-access round-key read port serves the datapath.

## Interface
Parameters:
- NK, 8, key length in 32-bit words (fixed at 8; other values unsupported).
- NR, 14, number of rounds; round keys produced = NR+1.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request expansion of key_in; sampled only in IDLE or DONE.
- key_in  in  256  cipher key; byte 0 in [255:248], byte 31 in [7:0].
- rk_sel  in  4  round-key index, 0..14.
- busy  out  1  expansion in progress.
- done  out  1  all 60 words valid; held until the next accepted start.
- rk_out  out  128  round key rk_sel = {w[4s], w[4s+1], w[4s+2], w[4s+3]}; w[4s] in [127:96].

## Operation
- Storage: 60 × 32-bit word registers w[0..59], plus a 6-bit word counter cnt and a state register.
- States:
  - IDLE: after reset. start=1 → load w[0..7] from key_in (w[0]=key_in[255:224]), set cnt=8, go to EXPAND.
  - EXPAND: each cycle write w[cnt] = w[cnt-8] ^ temp, then cnt++.
    - cnt%8==0: temp = SubWord(RotWord(w[cnt-1])) ^ {RCON[cnt/8],24'h0}.
    - cnt%8==4: temp = SubWord(w[cnt-1]).
    - otherwise: temp = w[cnt-1].
    - On the cycle writing w[59], go to DONE.
- RotWord: {b1,b2,b3,b0}. SubWord applies the AES S-box to each of the 4 bytes.
- RCON[1..7] = 01,02,04,08,10,20,40. Only indices 1..7 are ever used.
- DONE: done=1. start=1 restarts exactly as from IDLE (reload, cnt=8, EXPAND); done drops on that same edge.
- start in EXPAND is ignored; there is no abort and no queuing.
- key_in is sampled only on the accepting edge; later changes have no effect.
- rk_out is combinational from w[] and rk_sel, and is forced to 128'h0 when done=0 or rk_sel=15.
- busy = (state==EXPAND). done = (state==DONE).
- Reset (any time, including mid-EXPAND): state=IDLE, cnt=0, all w[]=0, busy=0, done=0, rk_out=0. A later start performs a full fresh expansion.

## Timing
- Cycle 0: start=1 sampled in IDLE or DONE. The edge ending cycle 0 loads w[0..7].
- Cycles 1..52: busy=1. The edge ending cycle k writes w[7+k].
- Cycle 53 onward: done=1, busy=0, and every rk_sel returns valid data.
- Start-to-done latency is 53 cycles.
- Restart from DONE: done=0 and busy=1 in the cycle after start is sampled.
- rk_out has zero-cycle read latency (same cycle as rk_sel change); there is no registered output.
- Reset is asynchronous assert. Deassertion is assumed synchronized externally; the first start is accepted on the first edge after rst_n rises.

## Structure
- Package aes_pkg holds:
  - the S-box constant (256 × 8);
  - the RCON constant array;
  - the state enum {IDLE, EXPAND, DONE};
  - localparams NWORDS=60 and NRK=15.
- Sub-module aes_sbox: combinational 8-bit in, 8-bit out lookup from aes_pkg. It is instantiated 4× for SubWord and is shareable with the SubBytes stage.
- One always_ff holds state, cnt and w[]. One always_comb computes temp and the rk_out mux.

## Test plan
- Reset and idle outputs: hold rst_n=0, then release → busy=0, done=0, rk_out=0 for all rk_sel; no change without start.
- Latency and first words, key 000102…1f: pulse start → busy high cycles 1..52, done at cycle 53. Then:
  - rk_sel=0 → 000102030405060708090a0b0c0d0e0f;
  - rk_sel=1 → 101112131415161718191a1b1c1d1e1f;
  - rk_sel=2 → a573c29fa176c498a97fce93a572c09c.
- Last round key, same key: rk_sel=14 → 24fc79ccbf0979e9371ac23c6d68de36. rk_sel=15 → 0.
- All-zero key: rk_sel=2 → 62636363626363636263636362636363. start pulsed again during EXPAND → ignored, done still at cycle 53 of the first start.
- Reset mid-op: assert rst_n=0 at cycle 20 → busy/done/rk_out=0 immediately. Restart with key 000102…1f → identical results to the latency-and-first-words scenario.
- Restart from DONE with a new key: done drops the next cycle and rises 53 cycles after the start. All 15 round keys match a reference model.
